core_ifu: RTL

- Instruction fetch unit for the RV32I five-stage pipeline, sitting directly upstream of the hazard control unit and the IF/ID register.
- Owns the PC and issues one instruction-memory read at a time over a valid/ready handshake.
- Holds the fetched word until the hazard unit allows the PC to advance.
- Reports memory busy/done status to the hazard unit and accepts branch/jump redirects.

---
 rtl/core_ifu.sv | 108 ++++++++++
 1 files changed

// File: rtl/core_ifu.sv
// core_ifu: RV32I fetch unit; owns the PC, runs one instruction-memory read at a time
// and holds the fetched word until the hazard unit lets the PC advance.
module core_ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        HCU_PC_WRITE,
    input  logic        C_PC_REDIRECT,
    input  logic [31:0] C_PC_TARGET,
    output logic        IMEM_AVALID,
    input  logic        IMEM_AREADY,
    output logic [31:0] IMEM_AADDR,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic        IF_VALID,
    output logic [31:0] IF_INSTR,
    output logic [31:0] IF_PC,
    output logic        HCU_IMEM_BUSY,
    output logic        HCU_IMEM_DONE
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] tgt;
    logic        capture;

    assign tgt = C_PC_TARGET & ~32'h3;
    // A response is kept only if no redirect happened while it was in flight, including this cycle
    assign capture = (state_q == S_WAIT) && IMEM_RVALID && !discard_q && !C_PC_REDIRECT;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = IMEM_AREADY ? S_WAIT : S_REQ;
            S_WAIT:  state_d = !IMEM_RVALID ? S_WAIT : capture ? S_HOLD : S_REQ;
            S_HOLD:  state_d = (C_PC_REDIRECT || HCU_PC_WRITE) ? S_REQ : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IMEM_AVALID   = state_q == S_REQ;
        HCU_IMEM_BUSY = (state_q == S_REQ) || (state_q == S_WAIT);
        IF_VALID      = state_q == S_HOLD;
        HCU_IMEM_DONE = capture;
    end

    assign IMEM_AADDR = pc_q;
    assign IF_INSTR   = instr_q;
    assign IF_PC      = if_pc_q;

    always_comb begin
        pc_d       = pc_q;
        pend_tgt_d = pend_tgt_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            S_IDLE: pc_d = C_PC_REDIRECT ? tgt : pc_q;
            S_REQ: begin
                discard_d  = discard_q || C_PC_REDIRECT;
                pend_tgt_d = C_PC_REDIRECT ? tgt : pend_tgt_q;
            end
            S_WAIT: begin
                if (capture) begin
                    instr_d = IMEM_RDATA;
                    if_pc_d = pc_q;
                end else if (IMEM_RVALID) begin
                    pc_d      = C_PC_REDIRECT ? tgt : pend_tgt_q;
                    discard_d = 1'b0;
                end else begin
                    discard_d  = discard_q || C_PC_REDIRECT;
                    pend_tgt_d = C_PC_REDIRECT ? tgt : pend_tgt_q;
                end
            end
            S_HOLD: pc_d = C_PC_REDIRECT ? tgt : HCU_PC_WRITE ? pc_q + 32'd4 : pc_q;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q       <= RESET_PC;
            pend_tgt_q <= 32'h0;
            discard_q  <= 1'b0;
            instr_q    <= 32'h0000_0013;
            if_pc_q    <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
        end
    end
endmodule
